// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the alu arbiter slice: op-code encoding, op count and
// the legality check used when capturing a result.
package alu_arbiter_pkg;

    localparam int ALU_OP_WIDTH = 4;
    localparam int ALU_OP_NUM   = 15;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_ADDI  = 4'd10,
        ALU_LUI   = 4'd11,
        ALU_PASSB = 4'd12,
        ALU_NOR   = 4'd13,
        ALU_ANDN  = 4'd14
    } alu_op_e;

    function automatic logic op_invalid(input logic [ALU_OP_WIDTH-1:0] op);
        return int'(op) >= ALU_OP_NUM;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Single combinational alu shared by both requesters; unknown op codes yield zero.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [ALU_OP_WIDTH-1:0] op,
    input  logic [XLEN-1:0]         a,
    input  logic [XLEN-1:0]         b,
    input  logic [XLEN-1:0]         imm,
    output logic [XLEN-1:0]         out
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        out = '0;
        case (alu_op_e'(op))
            ALU_ADD:   out = a + b;
            ALU_SUB:   out = a - b;
            ALU_AND:   out = a & b;
            ALU_OR:    out = a | b;
            ALU_XOR:   out = a ^ b;
            ALU_SLL:   out = a << shamt;
            ALU_SRL:   out = a >> shamt;
            ALU_SRA:   out = $signed(a) >>> shamt;
            ALU_SLT:   out = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:  out = {{(XLEN-1){1'b0}}, a < b};
            ALU_ADDI:  out = a + imm;
            ALU_LUI:   out = imm << 12;
            ALU_PASSB: out = b;
            ALU_NOR:   out = ~(a | b);
            ALU_ANDN:  out = a & ~b;
            default:   out = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one alu: grant, latch operands, compute, then hold
// the registered result until the owning port consumes it.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1,
    parameter int XLEN  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [ALU_OP_WIDTH-1:0] req_op0,
    input  logic [ALU_OP_WIDTH-1:0] req_op1,
    input  logic [XLEN-1:0]         req_imm0,
    input  logic [XLEN-1:0]         req_imm1,
    input  logic [XLEN-1:0]         req_a0,
    input  logic [XLEN-1:0]         req_a1,
    input  logic [XLEN-1:0]         req_b0,
    input  logic [XLEN-1:0]         req_b1,
    output logic [1:0]              rsp_valid,
    input  logic [1:0]              rsp_ready,
    output logic [XLEN-1:0]         rsp_data,
    output logic                    rsp_err
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t                  state, next_state;
    logic                    owner, last_grant, winner, any_valid;
    logic [ALU_OP_WIDTH-1:0] op_q;
    logic [XLEN-1:0]         a_q, b_q, imm_q, alu_out;

    // On a tie, round-robin picks the port that did not win last time.
    always_comb begin
        any_valid = |req_valid;
        winner    = 1'b0;
        if (req_valid == 2'b10)
            winner = 1'b1;
        else if (req_valid == 2'b11)
            winner = RR_EN ? ~last_grant : 1'b0;
    end

    always_comb begin
        next_state = state;
        req_ready  = 2'b00;
        rsp_valid  = 2'b00;
        case (state)
            S_IDLE: begin
                if (any_valid) begin
                    req_ready[winner] = rst_n;
                    next_state        = S_EXEC;
                end
            end
            S_EXEC: next_state = S_RESP;
            S_RESP: begin
                rsp_valid[owner] = 1'b1;
                if (rsp_ready[owner])
                    next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // The alu only ever sees the latched operands, never the live request buses.
    alu_arbiter_alu #(.XLEN(XLEN)) u_alu (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .imm (imm_q),
        .out (alu_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && any_valid) begin
                owner      <= winner;
                last_grant <= winner;
                op_q       <= winner ? req_op1  : req_op0;
                a_q        <= winner ? req_a1   : req_a0;
                b_q        <= winner ? req_b1   : req_b0;
                imm_q      <= winner ? req_imm1 : req_imm0;
            end
            if (state == S_EXEC) begin
                rsp_data <= op_invalid(op_q) ? '0 : alu_out;
                rsp_err  <= op_invalid(op_q);
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance and a fixed-priority
// instance share the same stimulus.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [3:0]  req_op0 = '0, req_op1 = '0;
    logic [31:0] req_imm0 = '0, req_imm1 = '0, req_a0 = '0, req_a1 = '0;
    logic [31:0] req_b0 = '0, req_b1 = '0;
    logic [1:0]  rsp_ready = '0;

    logic [1:0]  req_ready, rsp_valid, fp_req_ready, fp_rsp_valid;
    logic [31:0] rsp_data, fp_rsp_data;
    logic        rsp_err, fp_rsp_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.RR_EN(1'b1), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1), .req_imm0(req_imm0), .req_imm1(req_imm1),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    alu_arbiter #(.RR_EN(1'b0), .XLEN(32)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(fp_req_ready),
        .req_op0(req_op0), .req_op1(req_op1), .req_imm0(req_imm0), .req_imm1(req_imm1),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(fp_rsp_data),
        .rsp_err(fp_rsp_err)
    );

    // a=32'hAA, b=3, imm=2 worked by hand for op codes 0..15
    logic [31:0] sweep_exp [16] = '{
        32'h000000AD, 32'h000000A7, 32'h00000002, 32'h000000AB,
        32'h000000A9, 32'h00000550, 32'h00000015, 32'h00000015,
        32'h00000000, 32'h00000000, 32'h000000AC, 32'h00002000,
        32'h00000003, 32'hFFFFFF54, 32'h000000A8, 32'h00000000
    };

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic set_port(input int port, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] imm);
        if (port == 0) begin
            req_op0 = op; req_a0 = a; req_b0 = b; req_imm0 = imm;
        end else begin
            req_op1 = op; req_a1 = a; req_b1 = b; req_imm1 = imm;
        end
    endtask

    // Drives one request on a port and returns the response; ok=0 if a bound expired.
    task automatic run_op(input int port, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm,
                          output logic [31:0] data, output logic err, output logic ok);
        int i;
        ok   = 1'b1;
        data = '0;
        err  = 1'b0;
        set_port(port, op, a, b, imm);
        req_valid       = '0;
        req_valid[port] = 1'b1;
        #1;
        for (i = 0; i < 10 && req_ready[port] !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        if (i == 10) ok = 1'b0;
        @(posedge clk); #1;
        req_valid = '0;
        for (i = 0; i < 10 && rsp_valid[port] !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        if (i == 10) ok = 1'b0;
        data            = rsp_data;
        err             = rsp_err;
        rsp_ready[port] = 1'b1;
        @(posedge clk); #1;
        rsp_ready = '0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 2'b11;
        #2;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_err} !== 37'd0)
            $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b data=%h err=%b required all 0",
                     req_ready, rsp_valid, rsp_data, rsp_err);
        else n_pass++;
        n_checks++;
        if ({fp_req_ready, fp_rsp_valid, fp_rsp_data, fp_rsp_err} !== 37'd0)
            $display("[TB] FAIL reset_outputs_fp: got rdy=%b vld=%b required 0",
                     fp_req_ready, fp_rsp_valid);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_single_port();
        do_reset();
        set_port(0, ALU_ADD, 32'hAA, 32'h3, 32'h2);
        req_valid = 2'b01;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) $display("[TB] FAIL single_ready_T: got %b required 01", req_ready);
        else n_pass++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        n_checks++;
        if (rsp_valid !== 2'b00 || req_ready !== 2'b00)
            $display("[TB] FAIL single_exec_T1: got vld=%b rdy=%b required 00/00", rsp_valid, req_ready);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'hAD || rsp_err !== 1'b0)
            $display("[TB] FAIL single_resp_T2: got vld=%b data=%h err=%b required 01/000000ad/0",
                     rsp_valid, rsp_data, rsp_err);
        else n_pass++;
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        n_checks++;
        if (rsp_valid !== 2'b00) $display("[TB] FAIL single_release: got %b required 00", rsp_valid);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_rr, exp_fp;
        do_reset();
        set_port(0, ALU_ADD, 32'h1, 32'h1, 32'h0);
        set_port(1, ALU_SUB, 32'h5, 32'h1, 32'h0);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int i = 0; i < 12; i++) begin
            #1;
            exp_rr = (i % 3 != 0) ? 2'b00 : (((i / 3) % 2 == 0) ? 2'b01 : 2'b10);
            exp_fp = (i % 3 != 0) ? 2'b00 : 2'b01;
            n_checks++;
            if (req_ready !== exp_rr)
                $display("[TB] FAIL rr_grant[%0d]: got %b required %b", i, req_ready, exp_rr);
            else n_pass++;
            n_checks++;
            if (fp_req_ready !== exp_fp)
                $display("[TB] FAIL fp_grant[%0d]: got %b required %b", i, fp_req_ready, exp_fp);
            else n_pass++;
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
    endtask

    task automatic test_backpressure();
        do_reset();
        set_port(0, ALU_ADD, 32'hAA, 32'h3, 32'h2);
        set_port(1, ALU_SUB, 32'hAA, 32'h3, 32'h2);
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b10;
        @(posedge clk); #1;
        rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rsp_valid !== 2'b01 || rsp_data !== 32'hAD || req_ready !== 2'b00)
                $display("[TB] FAIL bp_hold[%0d]: got vld=%b data=%h rdy=%b required 01/000000ad/00",
                         i, rsp_valid, rsp_data, req_ready);
            else n_pass++;
            @(posedge clk); #1;
        end
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        n_checks++;
        if (req_ready !== 2'b10 || rsp_valid !== 2'b00)
            $display("[TB] FAIL bp_release: got rdy=%b vld=%b required 10/00", req_ready, rsp_valid);
        else n_pass++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid !== 2'b10 || rsp_data !== 32'hA7)
            $display("[TB] FAIL bp_port1_rsp: got vld=%b data=%h required 10/000000a7", rsp_valid, rsp_data);
        else n_pass++;
        rsp_ready = 2'b10;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
    endtask

    task automatic test_op_sweep();
        logic [31:0] data;
        logic        err, ok;
        do_reset();
        for (int op = 0; op < 16; op++) begin
            run_op(1, 4'(op), 32'hAA, 32'h3, 32'h2, data, err, ok);
            n_checks++;
            if (!ok || data !== sweep_exp[op] || err !== (op == 15))
                $display("[TB] FAIL sweep_op%0d: got ok=%b data=%h err=%b required 1/%h/%b",
                         op, ok, data, err, sweep_exp[op], op == 15);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        set_port(0, ALU_PASSB, 32'h0, 32'h1234, 32'h0);
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b11;
        rst_n     = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_err} !== 37'd0)
            $display("[TB] FAIL reset_exec: got rdy=%b vld=%b data=%h err=%b required all 0",
                     req_ready, rsp_valid, rsp_data, rsp_err);
        else n_pass++;
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rsp_valid !== 2'b00)
                $display("[TB] FAIL reset_no_rsp[%0d]: got %b required 00", i, rsp_valid);
            else n_pass++;
        end
        req_valid = 2'b11;
        #1;
        n_checks++;
        if (req_ready !== 2'b01)
            $display("[TB] FAIL reset_first_grant: got %b required 01", req_ready);
        else n_pass++;
        @(posedge clk); #1;
        req_valid = 2'b00;
    endtask

    task automatic test_drop_valid();
        int bad;
        do_reset();
        req_valid = 2'b11;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (req_ready[1] !== 1'b0) bad++;
        end
        rsp_ready = 2'b00;
        n_checks++;
        if (bad != 0) $display("[TB] FAIL drop_no_grant: got %0d port1 grants required 0", bad);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_round_robin();
        test_backpressure();
        test_op_sweep();
        test_reset_mid_op();
        test_drop_valid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
